// File: rtl/chicken_pkg.sv
// rtl/chicken_pkg.sv - shared state, player and picture definitions for the Chicken Cha-Cha-Cha game flow
package chicken_pkg;

  localparam int NUM_PLAYERS = 3;
  localparam int PIC_W       = 4;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P1     = 2'd1;
  localparam logic [1:0] P2     = 2'd2;
  localparam logic [1:0] P3     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FLIP = 3'd1,
    ST_EVAL      = 3'd2,
    ST_ADVANCE   = 3'd3,
    ST_CHECK     = 3'd4,
    ST_PASS      = 3'd5,
    ST_WIN       = 3'd6
  } state_e;

  // Turn order 1->2->3->1; never yields P_NONE.
  function automatic logic [1:0] next_player(input logic [1:0] p);
    return (p == P3) ? P1 : p + 2'd1;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// rtl/turn_sequencer_if.sv - card-flip input and move-strobe output bundle of turn_sequencer
interface turn_sequencer_if;
  import chicken_pkg::*;

  logic             start;
  logic             flip_valid;
  logic [3:0]       flip_idx;
  logic [PIC_W-1:0] flip_pic;
  logic [PIC_W-1:0] tile_pic;
  logic             W;
  logic [1:0]       T;
  logic             B;
  logic             turn_pulse;
  logic             flip_reject;
  logic             game_over;
  logic [1:0]       winner;

  modport master (
    output start, flip_valid, flip_idx, flip_pic, tile_pic, W,
    input  T, B, turn_pulse, flip_reject, game_over, winner
  );

  modport slave (
    input  start, flip_valid, flip_idx, flip_pic, tile_pic, W,
    output T, B, turn_pulse, flip_reject, game_over, winner
  );

endinterface

// File: rtl/turn_sequencer_turn_timer.sv
// rtl/turn_sequencer_turn_timer.sv - saturating per-turn wait counter with clear and expire
module turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - game-flow FSM: turn ownership, flip evaluation and advance strobes for check_win
import chicken_pkg::*;

module turn_sequencer #(
  parameter int unsigned NUM_CARDS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic            clk,
  input  logic            rst,
  turn_sequencer_if.slave bus
);

  state_e                 state_q, state_d;
  logic [1:0]             t_q, t_d;
  logic                   b_q, b_d;
  logic                   turn_pulse_q, turn_pulse_d;
  logic                   flip_reject_q, flip_reject_d;
  logic                   game_over_q, game_over_d;
  logic [1:0]             winner_q, winner_d;
  logic [NUM_CARDS-1:0]   mask_q, mask_d;
  logic [PIC_W-1:0]       flip_pic_q, flip_pic_d;
  logic [PIC_W-1:0]       tile_pic_q, tile_pic_d;

  logic tmr_clr, tmr_en, tmr_expire;
  logic idx_ok, flip_ok;

  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  assign idx_ok  = ({28'd0, bus.flip_idx} < NUM_CARDS);
  assign flip_ok = idx_ok && !mask_q[bus.flip_idx];

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    b_d           = 1'b0;
    turn_pulse_d  = 1'b0;
    flip_reject_d = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    mask_d        = mask_q;
    flip_pic_d    = flip_pic_q;
    tile_pic_d    = tile_pic_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          t_d          = P1;
          turn_pulse_d = 1'b1;
          mask_d       = '0;
          tmr_clr      = 1'b1;
          state_d      = ST_WAIT_FLIP;
        end
      end
      ST_WAIT_FLIP: begin
        tmr_en = 1'b1;
        // An accepted flip beats a timeout expiring in the same cycle.
        if (bus.flip_valid && flip_ok) begin
          flip_pic_d             = bus.flip_pic;
          tile_pic_d             = bus.tile_pic;
          mask_d[bus.flip_idx]   = 1'b1;
          tmr_clr                = 1'b1;
          state_d                = ST_EVAL;
        end else begin
          flip_reject_d = bus.flip_valid;
          if (tmr_expire) begin
            state_d = ST_PASS;
          end
        end
      end
      ST_EVAL: begin
        if (flip_pic_q == tile_pic_q) begin
          b_d     = 1'b1;
          state_d = ST_ADVANCE;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_ADVANCE: state_d = ST_CHECK;
      ST_CHECK: begin
        // check_win has consumed B by now, so W reflects this move.
        if (bus.W) begin
          winner_d    = t_q;
          game_over_d = 1'b1;
          state_d     = ST_WIN;
        end else begin
          state_d = ST_WAIT_FLIP;
        end
      end
      ST_PASS: begin
        t_d          = next_player(t_q);
        turn_pulse_d = 1'b1;
        mask_d       = '0;
        tmr_clr      = 1'b1;
        state_d      = ST_WAIT_FLIP;
      end
      ST_WIN:  state_d = ST_WIN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      t_q           <= P_NONE;
      b_q           <= 1'b0;
      turn_pulse_q  <= 1'b0;
      flip_reject_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= P_NONE;
      mask_q        <= '0;
      flip_pic_q    <= '0;
      tile_pic_q    <= '0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      b_q           <= b_d;
      turn_pulse_q  <= turn_pulse_d;
      flip_reject_q <= flip_reject_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      mask_q        <= mask_d;
      flip_pic_q    <= flip_pic_d;
      tile_pic_q    <= tile_pic_d;
    end
  end

  assign bus.T           = t_q;
  assign bus.B           = b_q;
  assign bus.turn_pulse  = turn_pulse_q;
  assign bus.flip_reject = flip_reject_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  turn_sequencer_if bus ();
  turn_sequencer_if bus_t ();

  turn_sequencer #(.NUM_CARDS(12), .TIMEOUT_CYCLES(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  turn_sequencer #(.NUM_CARDS(12), .TIMEOUT_CYCLES(8)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input logic [3:0] idx, input logic [3:0] fp, input logic [3:0] tp);
    bus.flip_valid = 1'b1;
    bus.flip_idx   = idx;
    bus.flip_pic   = fp;
    bus.tile_pic   = tp;
    step();
    bus.flip_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.flip_valid = 0; bus.flip_idx = 0; bus.flip_pic = 0; bus.tile_pic = 0; bus.W = 0;
    bus_t.start = 0; bus_t.flip_valid = 0; bus_t.flip_idx = 0; bus_t.flip_pic = 0; bus_t.tile_pic = 0; bus_t.W = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    vectors++;
    if ({bus.T, bus.B, bus.turn_pulse, bus.flip_reject, bus.game_over, bus.winner} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got T=%0d B=%b tp=%b rej=%b go=%b win=%0d, expected all zero",
               bus.T, bus.B, bus.turn_pulse, bus.flip_reject, bus.game_over, bus.winner);
    end
    vectors++;
    if ({bus_t.T, bus_t.B, bus_t.turn_pulse, bus_t.game_over, bus_t.winner} !== 7'h00) begin
      errors++;
      $display("FAIL reset_outputs_t: got T=%0d B=%b tp=%b go=%b win=%0d, expected all zero",
               bus_t.T, bus_t.B, bus_t.turn_pulse, bus_t.game_over, bus_t.winner);
    end
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if (bus.T !== 2'd1 || bus.turn_pulse !== 1'b1) begin
      errors++;
      $display("FAIL start_turn: got T=%0d tp=%b, expected T=1 tp=1", bus.T, bus.turn_pulse);
    end
    vectors++;
    if (bus.game_over !== 1'b0 || bus.winner !== 2'd0) begin
      errors++;
      $display("FAIL start_idle_flags: got go=%b win=%0d, expected 0 0", bus.game_over, bus.winner);
    end
    step();
    vectors++;
    if (bus.turn_pulse !== 1'b0 || bus.T !== 2'd1) begin
      errors++;
      $display("FAIL start_pulse_width: got T=%0d tp=%b, expected T=1 tp=0", bus.T, bus.turn_pulse);
    end
  endtask

  task automatic test_match();
    flip(4'd3, 4'd5, 4'd5);
    vectors++;
    if (bus.B !== 1'b0) begin
      errors++;
      $display("FAIL match_b_early: got B=%b, expected 0", bus.B);
    end
    step();
    vectors++;
    if (bus.B !== 1'b1 || bus.T !== 2'd1) begin
      errors++;
      $display("FAIL match_b: got B=%b T=%0d, expected B=1 T=1", bus.B, bus.T);
    end
    step();
    vectors++;
    if (bus.B !== 1'b0) begin
      errors++;
      $display("FAIL match_b_width: got B=%b, expected 0", bus.B);
    end
    step();
    flip(4'd3, 4'd5, 4'd5);
    vectors++;
    if (bus.flip_reject !== 1'b1) begin
      errors++;
      $display("FAIL repeat_reject: got rej=%b, expected 1", bus.flip_reject);
    end
    step();
    vectors++;
    if (bus.B !== 1'b0 || bus.flip_reject !== 1'b0 || bus.T !== 2'd1) begin
      errors++;
      $display("FAIL repeat_no_b: got B=%b rej=%b T=%0d, expected 0 0 1", bus.B, bus.flip_reject, bus.T);
    end
    flip(4'd12, 4'd5, 4'd5);
    vectors++;
    if (bus.flip_reject !== 1'b1) begin
      errors++;
      $display("FAIL idx_range_reject: got rej=%b, expected 1", bus.flip_reject);
    end
    flip(4'd11, 4'd1, 4'd1);
    vectors++;
    if (bus.flip_reject !== 1'b0) begin
      errors++;
      $display("FAIL idx_last_accept: got rej=%b, expected 0", bus.flip_reject);
    end
    step();
    vectors++;
    if (bus.B !== 1'b1) begin
      errors++;
      $display("FAIL idx_last_b: got B=%b, expected 1", bus.B);
    end
    step(); step();
  endtask

  task automatic test_mismatch_wrap();
    logic [1:0] exp_t [3] = '{2'd2, 2'd3, 2'd1};
    logic [3:0] idxs  [3] = '{4'd0, 4'd0, 4'd5};
    for (int i = 0; i < 3; i++) begin
      flip(idxs[i], 4'd2, 4'd7);
      step();
      vectors++;
      if (bus.turn_pulse !== 1'b0 || bus.B !== 1'b0) begin
        errors++;
        $display("FAIL mismatch_pass_%0d: got tp=%b B=%b, expected 0 0", i, bus.turn_pulse, bus.B);
      end
      step();
      vectors++;
      if (bus.T !== exp_t[i] || bus.turn_pulse !== 1'b1) begin
        errors++;
        $display("FAIL mismatch_turn_%0d: got T=%0d tp=%b, expected T=%0d tp=1", i, bus.T, bus.turn_pulse, exp_t[i]);
      end
    end
    flip(4'd3, 4'd4, 4'd4);
    vectors++;
    if (bus.flip_reject !== 1'b0) begin
      errors++;
      $display("FAIL mask_cleared: got rej=%b, expected 0", bus.flip_reject);
    end
    step();
    vectors++;
    if (bus.B !== 1'b1 || bus.T !== 2'd1) begin
      errors++;
      $display("FAIL mask_cleared_b: got B=%b T=%0d, expected B=1 T=1", bus.B, bus.T);
    end
    step(); step();
  endtask

  task automatic test_win();
    flip(4'd1, 4'd2, 4'd7);
    step(); step();
    flip(4'd2, 4'd9, 4'd9);
    step();
    vectors++;
    if (bus.B !== 1'b1 || bus.T !== 2'd2) begin
      errors++;
      $display("FAIL win_b: got B=%b T=%0d, expected B=1 T=2", bus.B, bus.T);
    end
    step();
    bus.W = 1'b1;
    vectors++;
    if (bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL win_early: got go=%b, expected 0", bus.game_over);
    end
    step();
    bus.W = 1'b0;
    vectors++;
    if (bus.game_over !== 1'b1 || bus.winner !== 2'd2 || bus.T !== 2'd2) begin
      errors++;
      $display("FAIL win_state: got go=%b win=%0d T=%0d, expected 1 2 2", bus.game_over, bus.winner, bus.T);
    end
    flip(4'd4, 4'd6, 4'd6);
    vectors++;
    if (bus.flip_reject !== 1'b0) begin
      errors++;
      $display("FAIL win_no_reject: got rej=%b, expected 0", bus.flip_reject);
    end
    step();
    vectors++;
    if (bus.B !== 1'b0 || bus.game_over !== 1'b1 || bus.winner !== 2'd2) begin
      errors++;
      $display("FAIL win_hold: got B=%b go=%b win=%0d, expected 0 1 2", bus.B, bus.game_over, bus.winner);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({bus.T, bus.B, bus.turn_pulse, bus.flip_reject, bus.game_over, bus.winner} !== 8'h00) begin
      errors++;
      $display("FAIL win_reset: got T=%0d B=%b go=%b win=%0d, expected all zero",
               bus.T, bus.B, bus.game_over, bus.winner);
    end
  endtask

  task automatic test_rst_on_b();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    flip(4'd6, 4'd3, 4'd3);
    step();
    vectors++;
    if (bus.B !== 1'b1) begin
      errors++;
      $display("FAIL rst_b_setup: got B=%b, expected 1", bus.B);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (bus.T !== 2'd0 || bus.B !== 1'b0 || bus.turn_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rst_on_b: got T=%0d B=%b tp=%b, expected 0 0 0", bus.T, bus.B, bus.turn_pulse);
    end
    step(); step();
    vectors++;
    if (bus.T !== 2'd0 || bus.B !== 1'b0) begin
      errors++;
      $display("FAIL rst_stays_idle: got T=%0d B=%b, expected 0 0", bus.T, bus.B);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic [1:0] exp_t [2] = '{2'd2, 2'd3};
    bus_t.start = 1'b1;
    step();
    bus_t.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (bus_t.turn_pulse !== 1'b1 && cyc < 50);
      vectors++;
      if (cyc != 9 || bus_t.T !== exp_t[i]) begin
        errors++;
        $display("FAIL timeout_%0d: got %0d cycles T=%0d, expected 9 cycles T=%0d", i, cyc, bus_t.T, exp_t[i]);
      end
    end
    repeat (7) step();
    bus_t.flip_valid = 1'b1; bus_t.flip_idx = 4'd0; bus_t.flip_pic = 4'd1; bus_t.tile_pic = 4'd1;
    step();
    bus_t.flip_valid = 1'b0;
    step();
    vectors++;
    if (bus_t.B !== 1'b1 || bus_t.T !== 2'd3) begin
      errors++;
      $display("FAIL timeout_flip_wins: got B=%b T=%0d, expected B=1 T=3", bus_t.B, bus_t.T);
    end
    step(); step();
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus_t.turn_pulse !== 1'b1 && cyc < 50);
    vectors++;
    if (cyc != 9 || bus_t.T !== 2'd1) begin
      errors++;
      $display("FAIL timeout_restart: got %0d cycles T=%0d, expected 9 cycles T=1", cyc, bus_t.T);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_match();
    test_mismatch_wrap();
    test_win();
    test_rst_on_b();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-flow controller for the Chicken Cha-Cha-Cha board: owns whose turn it is and turns raw card flips into the per-player move strobes that the win checker consumes. It drives `T` (current player) and `B` (single-cycle "advance one tile" strobe) toward `check_win`, samples its `W` back, and ends the game when a player wins. It sits between the card-flip input logic and `check_win`.

## Interface
Parameters:
- `NUM_CARDS`, 12: face-down cards on the table; `flip_idx` range is 0..NUM_CARDS-1.
- `TIMEOUT_CYCLES`, 1_000_000_000: cycles a player may wait before a flip; on expiry the turn passes.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; starts a game from IDLE.
- `flip_valid`  in  1  one-cycle strobe: a card was flipped.
- `flip_idx`  in  4  position of the flipped card.
- `flip_pic`  in  4  picture on the flipped card.
- `tile_pic`  in  4  picture on the tile ahead of the current player, supplied by the board logic.
- `W`  in  1  win flag from `check_win`.
- `T`  out  2  current player: 0 = none, 1..3 = player 1..3.
- `B`  out  1  one-cycle advance strobe for player `T`.
- `turn_pulse`  out  1  one cycle when `T` changes to a new player.
- `flip_reject`  out  1  one cycle when a flip is ignored.
- `game_over`  out  1  level; high in WIN.
- `winner`  out  2  player who won; 0 until a win.

## Operation
- States: IDLE, WAIT_FLIP, EVAL, ADVANCE, CHECK, PASS, WIN.
- IDLE: `T`=0. `start`=1 -> `T`=1, `turn_pulse`, clear flip mask and timeout counter, -> WAIT_FLIP.
- WAIT_FLIP: timeout counter increments each cycle. On `flip_valid`:
  - `flip_idx` >= NUM_CARDS, or the card's mask bit is already set this turn -> `flip_reject`, stay, counter not reset.
  - Otherwise latch `flip_pic` and `tile_pic`, set the mask bit, reset the counter, -> EVAL.
- Counter reaching TIMEOUT_CYCLES-1 with no accepted flip -> PASS.
- EVAL: match (`flip_pic`==`tile_pic`) -> ADVANCE; mismatch -> PASS.
- ADVANCE: `B`=1 for exactly this cycle, then -> CHECK.
- CHECK: sample `W`. `W`=1 -> `winner`=`T`, -> WIN. Otherwise the same player keeps the turn, -> WAIT_FLIP with the mask retained.
- PASS: `T` advances 1->2->3->1 (wrap, never 0). Pulse `turn_pulse`, clear the mask and counter, -> WAIT_FLIP.
- WIN: `game_over`=1. `T` and `winner` hold. All flips ignored without `flip_reject`. Only `rst` leaves WIN.
- `flip_valid` outside WAIT_FLIP is dropped silently.
- `start` outside IDLE is ignored.
- Flip mask is `NUM_CARDS` bits wide. Timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and saturates; it never wraps.

## Timing
- Reset: state IDLE; `T`=0, `B`=0, `turn_pulse`=0, `flip_reject`=0, `game_over`=0, `winner`=0; mask and counter zero.
- `rst` mid-game takes priority over every event in the same cycle and aborts any state, including WIN.
- All outputs are registered.
- Accepted flip (sampled at edge n): EVAL at n+1; `B` high during cycle n+2; `W` sampled at the end of n+3. `check_win` updates its counters on `B`, so `W` is valid one cycle after `B`.
- Mismatch: `T` changes and `turn_pulse` is high in cycle n+3.
- `flip_reject` is high the cycle after the offending `flip_valid`.
- Minimum spacing between accepted flips is 4 cycles. Flips arriving while the block is busy are dropped.
- Timeout firing in the same cycle as an accepted `flip_valid`: the flip wins and the counter resets.

## Structure
- Shared package `chicken_pkg`:
  - state enum;
  - player encoding constants `P_NONE`=0, `P1`..`P3`;
  - `NUM_PLAYERS`=3;
  - `PIC_W`=4.
- One sub-module, `turn_timer`: the saturating timeout counter with clear and an expire output. The rest is a single FSM with datapath.

## Test plan
- Reset then `start` -> `T`=1, `turn_pulse` 1 cycle, `game_over`=0, `winner`=0.
- Player 1 flips idx 3 with `flip_pic`=5, `tile_pic`=5 -> `B` high exactly 2 cycles after the flip strobe; `T` stays 1; flip idx 3 again -> `flip_reject`, no `B`.
- Mismatch (`flip_pic`=2, `tile_pic`=7) on player 3 -> `T`=1 (wrap), `turn_pulse`, mask cleared so idx 3 is accepted again.
- `TIMEOUT_CYCLES`=8, no flips -> `T` advances 1->2 after 8 cycles in WAIT_FLIP, then 2->3 after 8 more.
- Match with `W` forced to 1 the cycle after `B`, `T`=2 -> `winner`=2, `game_over`=1; further flips give no `B` and no `flip_reject`; `rst` -> all outputs zero.
- `rst` asserted in the cycle `B` is high -> next cycle IDLE, `B`=0, `T`=0.
